// File: rtl/core0_pkg.sv
// core0_pkg: shared ALU opcodes and arbiter grant type
package core0_pkg;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_CARRY  = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_BORROW = 4'h4;
  localparam logic [3:0] OP_AND    = 4'h5;
  localparam logic [3:0] OP_OR     = 4'h6;
  localparam logic [3:0] OP_XOR    = 4'h7;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_P, GRANT_S} alu_grant_t;
endpackage

// File: rtl/alu_grant.sv
// alu_grant: primary-priority ALU grant with bounded secondary starvation
// Ports: clk, reset (async, active-high); p_valid/s_valid requests; halt blocks grants;
//        p_ready/s_ready handshakes; grant names the requester accepted this cycle.
module alu_grant
  import core0_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_valid,
  input  logic       s_valid,
  input  logic       halt,
  output logic       p_ready,
  output logic       s_ready,
  output alu_grant_t grant
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve;
  logic force_s;
  assign force_s = starve == SW'(STARVE_LIMIT);
  always_comb begin
    p_ready = !halt && !(force_s && s_valid);
    s_ready = !halt && ((force_s && s_valid) || !p_valid);
    grant   = (p_valid && p_ready) ? GRANT_P : (s_valid && s_ready) ? GRANT_S : GRANT_NONE;
  end
  // Frozen under halt; saturates at the limit so force_s stays up until the secondary wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve <= '0;
    else if (!halt) starve <= (!s_valid || grant == GRANT_S) ? '0 : force_s ? starve : starve + 1'b1;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between primary and secondary requesters
// Ports: clk, reset (async, active-high); p_*/s_* request handshakes and operands;
//        alu_* drive the ALU and alu_out/alu_oc/alu_oo return its result; halt blocks grants;
//        res with p_res_valid/s_res_valid is the registered result; carry/overflow are the flags.
module alu_arbiter
  import core0_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [WORD_WIDTH-1:0] p_a,
  input  logic [WORD_WIDTH-1:0] p_b,
  input  logic                  p_ic,
  input  logic [3:0]            p_opcode,
  input  logic                  p_store_carry,
  input  logic                  p_store_overflow,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_a,
  input  logic [WORD_WIDTH-1:0] s_b,
  input  logic                  s_ic,
  input  logic [3:0]            s_opcode,
  output logic [WORD_WIDTH-1:0] alu_a,
  output logic [WORD_WIDTH-1:0] alu_b,
  output logic                  alu_ic,
  output logic [3:0]            alu_opcode,
  input  logic [WORD_WIDTH-1:0] alu_out,
  input  logic                  alu_oc,
  input  logic                  alu_oo,
  input  logic                  halt,
  output logic                  p_res_valid,
  output logic                  s_res_valid,
  output logic [WORD_WIDTH-1:0] res,
  output logic                  carry,
  output logic                  overflow
);
  alu_grant_t grant;
  logic sel_p, sel_s;
  alu_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk(clk),
    .reset(reset),
    .p_valid(p_valid),
    .s_valid(s_valid),
    .halt(halt),
    .p_ready(p_ready),
    .s_ready(s_ready),
    .grant(grant)
  );
  assign sel_p = grant == GRANT_P;
  assign sel_s = grant == GRANT_S;
  // Idle cycles present the primary fields with a NOP so the ALU inputs stay quiet.
  always_comb begin
    alu_a      = sel_s ? s_a : p_a;
    alu_b      = sel_s ? s_b : p_b;
    alu_ic     = sel_s ? s_ic : p_ic;
    alu_opcode = sel_p ? p_opcode : sel_s ? s_opcode : OP_NOP;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res         <= '0;
      p_res_valid <= 1'b0;
      s_res_valid <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      p_res_valid <= sel_p;
      s_res_valid <= sel_s;
      if (sel_p || sel_s) res <= alu_out;
      if (sel_p && p_store_carry) carry <= alu_oc;
      if (sel_p && p_store_overflow) overflow <= alu_oo;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table plus scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import core0_pkg::*;
  localparam logic T = 1'b1, F = 1'b0;
  logic clk = 0, reset = 1;
  logic p_valid = 0, p_ic = 0, p_store_carry = 0, p_store_overflow = 0;
  logic s_valid = 0, s_ic = 0, halt = 0;
  logic [31:0] p_a = 0, p_b = 0, s_a = 0, s_b = 0;
  logic [3:0] p_opcode = 0, s_opcode = 0;
  logic p_ready, s_ready, alu_ic, alu_oc, alu_oo, p_res_valid, s_res_valid, carry, overflow;
  logic [31:0] alu_a, alu_b, alu_out, res;
  logic [3:0] alu_opcode;
  int checks = 0, failures = 0;

  alu_arbiter #(.WORD_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_ready(p_ready), .p_a(p_a), .p_b(p_b), .p_ic(p_ic), .p_opcode(p_opcode),
    .p_store_carry(p_store_carry), .p_store_overflow(p_store_overflow),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_ic(s_ic), .s_opcode(s_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_oc(alu_oc), .alu_oo(alu_oo), .halt(halt),
    .p_res_valid(p_res_valid), .s_res_valid(s_res_valid), .res(res), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pv; logic [31:0] pa, pb; logic pic; logic [3:0] pop; logic psc, pso;
    logic sv; logic [31:0] sa, sb; logic sic; logic [3:0] sop;
    logic hlt;
    alu_grant_t g; logic [31:0] r; logic c, o;
  } vec_t;
  typedef struct { alu_grant_t g; logic [31:0] r; logic c, o; } exp_t;
  exp_t q[$];
  exp_t e;
  vec_t tbl[13];
  logic [31:0] last_res = 0;
  logic ec = 0, eo = 0;

  // Reference ALU: {overflow, carry, result}
  function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, b, input logic ic);
    logic [31:0] b2;
    logic [32:0] s;
    b2 = (op == OP_SUB || op == OP_BORROW) ? ~b : b;
    s = {1'b0, a} + {1'b0, b2} + {32'b0, ic};
    case (op)
      OP_ADD, OP_CARRY, OP_SUB, OP_BORROW: return {(a[31] == b2[31]) && (s[31] != a[31]), s[32], s[31:0]};
      OP_AND: return {2'b0, a & b};
      OP_OR:  return {2'b0, a | b};
      OP_XOR: return {2'b0, a ^ b};
      default: return {2'b0, a};
    endcase
  endfunction

  always_comb {alu_oo, alu_oc, alu_out} = alu_f(alu_opcode, alu_a, alu_b, alu_ic);

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t x;
    @(negedge clk);
    p_valid = v.pv; p_a = v.pa; p_b = v.pb; p_ic = v.pic; p_opcode = v.pop;
    p_store_carry = v.psc; p_store_overflow = v.pso;
    s_valid = v.sv; s_a = v.sa; s_b = v.sb; s_ic = v.sic; s_opcode = v.sop; halt = v.hlt;
    x.g = v.g; x.r = v.r; x.c = v.c; x.o = v.o;
    q.push_back(x);
    last_res = v.r; ec = v.c; eo = v.o;
    #1;
    if (v.pv) chk("p_ready", {31'b0, p_ready}, {31'b0, v.g == GRANT_P});
    if (v.sv) chk("s_ready", {31'b0, s_ready}, {31'b0, v.g == GRANT_S});
  endtask

  task automatic drive_model(input vec_t v);
    logic [33:0] x;
    v.r = last_res; v.c = ec; v.o = eo;
    if (v.g == GRANT_P) begin
      x = alu_f(v.pop, v.pa, v.pb, v.pic);
      v.r = x[31:0];
      if (v.psc) v.c = x[32];
      if (v.pso) v.o = x[33];
    end else if (v.g == GRANT_S) begin
      x = alu_f(v.sop, v.sa, v.sb, v.sic);
      v.r = x[31:0];
    end
    drive(v);
  endtask

  // Scoreboard: each driven cycle's expectation is checked just after the following edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("p_res_valid", {31'b0, p_res_valid}, {31'b0, e.g == GRANT_P});
      chk("s_res_valid", {31'b0, s_res_valid}, {31'b0, e.g == GRANT_S});
      chk("res", res, e.r);
      chk("carry", {31'b0, carry}, {31'b0, e.c});
      chk("overflow", {31'b0, overflow}, {31'b0, e.o});
    end
  end

  initial begin
    vec_t v;
    int np;
    tbl[0]  = '{T, 32'hFFFF_FFFF, 32'h1, F, OP_ADD, T, T, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'h0, T, F};
    tbl[1]  = '{F, 32'h0, 32'h0, F, OP_NOP, F, F, T, 32'd10, 32'd5, F, OP_ADD, F, GRANT_S, 32'd15, T, F};
    tbl[2]  = '{T, 32'h7FFF_FFFF, 32'h1, F, OP_ADD, F, T, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'h8000_0000, T, T};
    tbl[3]  = '{T, 32'hFFFF_FFFF, 32'h2, F, OP_ADD, T, F, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'h1, T, T};
    tbl[4]  = '{T, 32'd5, 32'd6, T, OP_CARRY, T, T, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'd12, F, F};
    tbl[5]  = '{T, 32'd10, 32'd3, T, OP_SUB, T, F, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'd7, T, F};
    tbl[6]  = '{T, 32'd0, 32'd1, T, OP_BORROW, T, T, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'hFFFF_FFFF, F, F};
    tbl[7]  = '{F, 32'h0, 32'h0, F, OP_NOP, F, F, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_NONE, 32'hFFFF_FFFF, F, F};
    tbl[8]  = '{T, 32'hF0F0_F0F0, 32'hFF00_FF00, F, OP_AND, T, T, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'hF000_F000, F, F};
    tbl[9]  = '{F, 32'h0, 32'h0, F, OP_NOP, F, F, T, 32'hAAAA_5555, 32'hFFFF_0000, F, OP_XOR, F, GRANT_S, 32'h5555_5555, F, F};
    tbl[10] = '{T, 32'h1, 32'h1, F, OP_ADD, T, T, F, 32'h0, 32'h0, F, OP_NOP, T, GRANT_NONE, 32'h5555_5555, F, F};
    tbl[11] = '{T, 32'h1234_0000, 32'h0000_5678, F, OP_OR, F, F, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'h1234_5678, F, F};
    tbl[12] = '{T, 32'h8000_0000, 32'hFFFF_FFFF, F, OP_ADD, T, T, F, 32'h0, 32'h0, F, OP_NOP, F, GRANT_P, 32'h7FFF_FFFF, T, T};
    @(negedge clk);
    chk("reset_res", res, 32'h0);
    chk("reset_strobes", {30'b0, p_res_valid, s_res_valid}, 32'h0);
    chk("reset_flags", {30'b0, carry, overflow}, 32'h0);
    reset = 0;
    foreach (tbl[i]) drive(tbl[i]);
    // Asynchronous reset while a primary accept with flag writes is pending.
    @(negedge clk);
    p_valid = 1; p_a = 32'hFFFF_FFFF; p_b = 32'h1; p_ic = 0; p_opcode = OP_ADD;
    p_store_carry = 1; p_store_overflow = 1; s_valid = 0; halt = 0;
    #2 reset = 1;
    #1;
    chk("async_reset_res", res, 32'h0);
    chk("async_reset_strobe", {31'b0, p_res_valid}, 32'h0);
    chk("async_reset_flags", {30'b0, carry, overflow}, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_discard_strobe", {31'b0, p_res_valid}, 32'h0);
    chk("reset_discard_res", res, 32'h0);
    chk("reset_discard_carry", {31'b0, carry}, 32'h0);
    @(negedge clk);
    reset = 0; p_valid = 0;
    last_res = 0; ec = 0; eo = 0;
    // Starvation: both valid; secondary forced through every fifth cycle.
    np = 0;
    v = tbl[7];
    v.pv = T; v.pb = 32'd100; v.pic = F; v.pop = OP_ADD; v.psc = F; v.pso = F;
    v.sv = T; v.sa = 32'h1000; v.sb = 32'h7; v.sic = F; v.sop = OP_OR; v.hlt = F;
    for (int i = 0; i < 7; i++) begin
      v.pa = np;
      v.g = (i % 5 == 4) ? GRANT_S : GRANT_P;
      if (v.g == GRANT_P) np++;
      drive_model(v);
    end
    // Halt with both valid: no grants, counter frozen at 2.
    v.hlt = T; v.g = GRANT_NONE; v.pa = np;
    for (int i = 0; i < 3; i++) begin
      drive_model(v);
      if (i == 0) chk("strobe_under_halt", {31'b0, p_res_valid}, 32'h1);
    end
    v.hlt = F;
    for (int i = 0; i < 4; i++) begin
      v.pa = np;
      v.g = (i == 2) ? GRANT_S : GRANT_P;
      if (v.g == GRANT_P) np++;
      drive_model(v);
    end
    v.pv = F; v.sv = F; v.g = GRANT_NONE;
    drive_model(v);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
